// File: rtl/risc_toy_fetch.sv
// risc_toy_fetch: instruction-fetch stage plus IF/ID register for RISC_TOY.
// Owns the fetch PC, issues one-cycle-latency instruction memory reads and
// queues responses in a 2-entry buffer whose head feeds decode.
// Optional build macro: RISC_TOY_FETCH_PERF_EN adds FETCH_CNT / BUBBLE_CNT.
module risc_toy_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic [29:0] IADDR,
    output logic        IREQ,
    input  logic [31:0] INSTR,
    input  logic        STALL_D,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        VALID_D,
    output logic [31:0] INSTR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCADD4_D
`ifdef RISC_TOY_FETCH_PERF_EN
    ,
    output logic [31:0] FETCH_CNT,
    output logic [31:0] BUBBLE_CNT
`endif
);

    localparam int unsigned DEPTH = 2;
    localparam logic [1:0]  CNT_FULL = 2'(DEPTH);

    // Architectural state
    logic [31:0] pc_f, pc_f_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        inflight, inflight_n;
    logic        discard, discard_n;
    logic [1:0]  count, count_n;
    logic [31:0] head_instr, head_instr_n;
    logic [31:0] head_pc, head_pc_n;
    logic [31:0] tail_instr, tail_instr_n;
    logic [31:0] tail_pc, tail_pc_n;

    logic        pop;
    logic        push;
    logic [1:0]  occupancy;
    logic        unused_redirect_lsb;

    // Byte-offset bits of the redirect target are architecturally ignored
    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

    // Decode-facing outputs come straight from the head registers, zeroed when empty
    always_comb begin
        VALID_D  = (count != 2'd0);
        INSTR_D  = VALID_D ? head_instr : 32'h0;
        PC_D     = VALID_D ? head_pc : 32'h0;
        PCADD4_D = VALID_D ? (head_pc + 32'd4) : 32'h0;
        IADDR    = pc_f[31:2];
    end

    // Issue/pop/push decisions and next-state for PC, response tracking and buffer
    always_comb begin
        pc_f_n       = pc_f;
        pend_pc_n    = pend_pc;
        inflight_n   = 1'b0;
        discard_n    = 1'b0;
        count_n      = count;
        head_instr_n = head_instr;
        head_pc_n    = head_pc;
        tail_instr_n = tail_instr;
        tail_pc_n    = tail_pc;

        pop       = VALID_D & ~STALL_D & ~REDIRECT;
        occupancy = count + 2'(inflight);
        IREQ      = RSTN & ~REDIRECT & ((occupancy < CNT_FULL) | pop);
        // A response landing in a redirect cycle is already dropped by the flush
        push      = inflight & ~discard & ~REDIRECT;

        inflight_n = IREQ;
        if (IREQ) begin
            pend_pc_n = pc_f;
            pc_f_n    = pc_f + 32'd4;
        end

        if (REDIRECT) begin
            pc_f_n    = {REDIRECT_PC[31:2], 2'b00};
            count_n   = 2'd0;
            discard_n = inflight;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr_n = INSTR;
                        head_pc_n    = pend_pc;
                    end else begin
                        tail_instr_n = INSTR;
                        tail_pc_n    = pend_pc;
                    end
                    count_n = count + 2'd1;
                end
                2'b01: begin
                    head_instr_n = tail_instr;
                    head_pc_n    = tail_pc;
                    count_n      = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_instr_n = INSTR;
                        head_pc_n    = pend_pc;
                    end else begin
                        head_instr_n = tail_instr;
                        head_pc_n    = tail_pc;
                        tail_instr_n = INSTR;
                        tail_pc_n    = pend_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_f       <= {RESET_PC[31:2], 2'b00};
            pend_pc    <= 32'h0;
            inflight   <= 1'b0;
            discard    <= 1'b0;
            count      <= 2'd0;
            head_instr <= 32'h0;
            head_pc    <= 32'h0;
            tail_instr <= 32'h0;
            tail_pc    <= 32'h0;
        end else begin
            pc_f       <= pc_f_n;
            pend_pc    <= pend_pc_n;
            inflight   <= inflight_n;
            discard    <= discard_n;
            count      <= count_n;
            head_instr <= head_instr_n;
            head_pc    <= head_pc_n;
            tail_instr <= tail_instr_n;
            tail_pc    <= tail_pc_n;
        end
    end

`ifdef RISC_TOY_FETCH_PERF_EN
    // Performance counters: delivered instructions and empty-head cycles
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            FETCH_CNT  <= 32'h0;
            BUBBLE_CNT <= 32'h0;
        end else begin
            if (pop) begin
                FETCH_CNT <= FETCH_CNT + 32'd1;
            end
            if (!VALID_D) begin
                BUBBLE_CNT <= BUBBLE_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: memory returns word = byte address,
// expected PC stream kept in a scoreboard queue and checked on every pop.
module tb_risc_toy_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [29:0] iaddr0, iaddr1;
    logic        ireq0, ireq1;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1;
    logic [31:0] instr_d0, pc_d0, pc4_d0;
    logic [31:0] instr_d1, pc_d1, pc4_d1;
`ifdef RISC_TOY_FETCH_PERF_EN
    logic [31:0] fc0, bc0, fc1, bc1;
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;
    logic [31:0] sb[$];

    risc_toy_fetch #(.RESET_PC(32'h0000_0000)) u0 (
        .CLK(clk), .RSTN(rstn), .IADDR(iaddr0), .IREQ(ireq0), .INSTR(instr0),
        .STALL_D(stall), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .VALID_D(valid0), .INSTR_D(instr_d0), .PC_D(pc_d0), .PCADD4_D(pc4_d0)
`ifdef RISC_TOY_FETCH_PERF_EN
        , .FETCH_CNT(fc0), .BUBBLE_CNT(bc0)
`endif
    );

    risc_toy_fetch #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .CLK(clk), .RSTN(rstn), .IADDR(iaddr1), .IREQ(ireq1), .INSTR(instr1),
        .STALL_D(stall), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .VALID_D(valid1), .INSTR_D(instr_d1), .PC_D(pc_d1), .PCADD4_D(pc4_d1)
`ifdef RISC_TOY_FETCH_PERF_EN
        , .FETCH_CNT(fc1), .BUBBLE_CNT(bc1)
`endif
    );

    // One-cycle-latency instruction memories returning the requested byte address
    always @(posedge clk) begin
        instr0 <= ireq0 ? {iaddr0, 2'b00} : 32'hDEAD_BEEF;
        instr1 <= ireq1 ? {iaddr1, 2'b00} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(start + 32'(4 * i));
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then score any pop this cycle
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (valid0 && !st && !rd) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_empty observed=%h expected=none", pc_d0);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc", pc_d0, e);
                chk("sb_instr", instr_d0, e);
                chk("sb_pc4", pc4_d0, e + 32'd4);
                n_pops++;
            end
        end else if (!valid0) begin
            chk("idle_instr", instr_d0, 32'h0);
            chk("idle_pc", pc_d0, 32'h0);
            chk("idle_pc4", pc4_d0, 32'h0);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ireq", 32'(ireq0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_iaddr0", 32'(iaddr0), 32'h0);
        chk("rst_iaddr1", 32'(iaddr1), 32'h3FFF_FFFE);
        chk("rst_pc_d", pc_d0, 32'h0);
`ifdef RISC_TOY_FETCH_PERF_EN
        chk("rst_fcnt", fc0, 32'h0);
        chk("rst_bcnt", bc0, 32'h0);
`endif

        // Reset release and streaming start
        @(negedge clk);
        rstn = 1'b1;
        expect_run(32'h0, 64);
        #1;
        chk("first_ireq", 32'(ireq0), 32'd1);
        chk("first_iaddr", 32'(iaddr0), 32'h0);
        chk("first_valid", 32'(valid0), 32'd0);

        step(1'b0, 1'b0, 32'h0);
        chk("c1_valid", 32'(valid0), 32'd0);
        chk("c1_ireq", 32'(ireq0), 32'd1);
        chk("c1_iaddr", 32'(iaddr0), 32'h1);

        step(1'b0, 1'b0, 32'h0);
        chk("c2_valid", 32'(valid0), 32'd1);
        chk("c2_pc_d", pc_d0, 32'h0);
        chk("wrap_pc0", pc_d1, 32'hFFFF_FFF8);
        chk("wrap_pc4_0", pc4_d1, 32'hFFFF_FFFC);
        chk("wrap_instr0", instr_d1, 32'hFFFF_FFF8);
`ifdef RISC_TOY_FETCH_PERF_EN
        chk("bubble_2", bc0, 32'd2);
`endif

        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", pc_d1, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", pc4_d1, 32'h0);

        // Stall four cycles with head at 0x8
        step(1'b1, 1'b0, 32'h0);
        chk("wrap_pc2", pc_d1, 32'h0);
        chk("wrap_valid2", 32'(valid1), 32'd1);
        chk("stall0_pc", pc_d0, 32'h8);
        chk("stall0_ireq", 32'(ireq0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stall_pc", pc_d0, 32'h8);
            chk("stall_valid", 32'(valid0), 32'd1);
            chk("stall_ireq", 32'(ireq0), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("release_ireq", 32'(ireq0), 32'd1);
        chk("release_iaddr", 32'(iaddr0), 32'h4);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        // Redirect in steady state
        step(1'b0, 1'b1, 32'h0000_0100);
        chk("redir_ireq", 32'(ireq0), 32'd0);
        sb.delete();
        expect_run(32'h100, 64);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_valid1", 32'(valid0), 32'd0);
        chk("redir_ireq1", 32'(ireq0), 32'd1);
        chk("redir_iaddr", 32'(iaddr0), 32'h40);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_valid2", 32'(valid0), 32'd0);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_valid3", 32'(valid0), 32'd1);
        chk("redir_pc3", pc_d0, 32'h100);

        // Redirect together with stall, unaligned target
        step(1'b1, 1'b1, 32'h0000_0203);
        chk("rs_ireq", 32'(ireq0), 32'd0);
        sb.delete();
        expect_run(32'h200, 64);
        step(1'b0, 1'b0, 32'h0);
        chk("rs_valid", 32'(valid0), 32'd0);
        chk("rs_ireq1", 32'(ireq0), 32'd1);
        chk("rs_iaddr", 32'(iaddr0), 32'h80);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("rs_pc", pc_d0, 32'h200);
        step(1'b0, 1'b0, 32'h0);

        // Fill buffer, then pulse reset mid-stream
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("full_valid", 32'(valid0), 32'd1);
        chk("full_ireq", 32'(ireq0), 32'd0);
        chk("full_pc", pc_d0, 32'h208);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid0), 32'd0);
        chk("mid_rst_ireq", 32'(ireq0), 32'd0);
        chk("mid_rst_iaddr", 32'(iaddr0), 32'h0);
`ifdef RISC_TOY_FETCH_PERF_EN
        chk("mid_rst_fcnt", fc0, 32'h0);
`endif
        @(negedge clk);
        rstn  = 1'b1;
        stall = 1'b0;
        sb.delete();
        expect_run(32'h0, 64);
        n_pops = 0;
        #1;
        chk("rel_ireq", 32'(ireq0), 32'd1);
        chk("rel_iaddr", 32'(iaddr0), 32'h0);
        repeat (6) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
`ifdef RISC_TOY_FETCH_PERF_EN
        chk("fetch_cnt", fc0, 32'(n_pops));
`endif
        chk("rel_head", pc_d0, 32'(4 * n_pops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
